// File: rtl/fft_frame_ctrl.sv
// FFT frame controller: IDLE/FILL buffer N upstream samples, ISSUE streams them
// to the core without gaps, DRAIN tags core results with frame position.
module fft_frame_ctrl #(
    parameter int WIDTH   = 32,
    parameter int N       = 16,
    parameter int TIMEOUT = 256
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [WIDTH-1:0]     s_real,
    input  logic [WIDTH-1:0]     s_imag,
    output logic                 core_input_en,
    output logic [WIDTH-1:0]     core_input_real,
    output logic [WIDTH-1:0]     core_input_imag,
    input  logic                 core_output_en,
    input  logic [WIDTH-1:0]     core_output_real,
    input  logic [WIDTH-1:0]     core_output_imag,
    output logic                 m_valid,
    output logic [WIDTH-1:0]     m_real,
    output logic [WIDTH-1:0]     m_imag,
    output logic [$clog2(N)-1:0] m_index,
    output logic                 m_first,
    output logic                 m_last,
    output logic                 busy,
    output logic [15:0]          frame_count,
    output logic                 err_timeout,
    output logic                 err_spurious
);
    localparam int IW = $clog2(N);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, FILL, ISSUE, DRAIN} state_t;

    state_t          state, state_next;
    logic [IW-1:0]   wr_cnt, rd_cnt, out_cnt;
    logic [TW-1:0]   idle_cnt;
    logic [WIDTH-1:0] buf_real [N];
    logic [WIDTH-1:0] buf_imag [N];
    logic            accept;
    logic [IW-1:0]   wr_addr;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next      = state;
        s_ready         = 1'b0;
        busy            = 1'b1;
        core_input_en   = 1'b0;
        core_input_real = '0;
        core_input_imag = '0;
        case (state)
            IDLE: begin
                s_ready = 1'b1;
                busy    = 1'b0;
                if (s_valid) state_next = FILL;
            end
            FILL: begin
                s_ready = 1'b1;
                if (s_valid && wr_cnt == LAST_IDX) state_next = ISSUE;
            end
            ISSUE: begin
                core_input_en   = 1'b1;
                core_input_real = buf_real[rd_cnt];
                core_input_imag = buf_imag[rd_cnt];
                if (rd_cnt == LAST_IDX) state_next = DRAIN;
            end
            DRAIN: begin
                if (core_output_en) begin
                    if (out_cnt == LAST_IDX) state_next = IDLE;
                end else if (idle_cnt == IDLE_LAST) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept  = s_valid && s_ready;
    assign wr_addr = (state == IDLE) ? '0 : wr_cnt;

    // Sample storage carries no reset; contents are irrelevant until refilled.
    always_ff @(posedge clock) begin
        if (accept) begin
            buf_real[wr_addr] <= s_real;
            buf_imag[wr_addr] <= s_imag;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_cnt       <= '0;
            rd_cnt       <= '0;
            out_cnt      <= '0;
            idle_cnt     <= '0;
            m_valid      <= 1'b0;
            m_real       <= '0;
            m_imag       <= '0;
            m_index      <= '0;
            m_first      <= 1'b0;
            m_last       <= 1'b0;
            frame_count  <= '0;
            err_timeout  <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            m_valid <= 1'b0;
            m_first <= 1'b0;
            m_last  <= 1'b0;
            if (core_output_en && state != DRAIN) err_spurious <= 1'b1;
            case (state)
                IDLE: begin
                    if (s_valid) wr_cnt <= IW'(1);
                end
                FILL: begin
                    if (s_valid) begin
                        wr_cnt <= wr_cnt + 1'b1;
                        if (wr_cnt == LAST_IDX) rd_cnt <= '0;
                    end
                end
                ISSUE: begin
                    rd_cnt <= rd_cnt + 1'b1;
                    if (rd_cnt == LAST_IDX) begin
                        out_cnt  <= '0;
                        idle_cnt <= '0;
                    end
                end
                DRAIN: begin
                    if (core_output_en) begin
                        m_valid  <= 1'b1;
                        m_real   <= core_output_real;
                        m_imag   <= core_output_imag;
                        m_index  <= out_cnt;
                        m_first  <= (out_cnt == '0);
                        m_last   <= (out_cnt == LAST_IDX);
                        out_cnt  <= out_cnt + 1'b1;
                        idle_cnt <= '0;
                        if (out_cnt == LAST_IDX) frame_count <= frame_count + 16'd1;
                    end else if (idle_cnt == IDLE_LAST) begin
                        err_timeout <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/fft_frame_ctrl.md
FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32: sample component width, two's complement.
REQ-002 SHALL have parameter N, default 16: FFT frame length, a power of 4.
REQ-003 SHALL have parameter TIMEOUT, default 256: maximum idle cycles allowed in DRAIN.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all logic on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port s_valid, input, 1 bit: upstream sample valid.
REQ-007 SHALL have port s_ready, output, 1 bit: controller accepts a sample; a transfer occurs when s_valid and s_ready are both high on a rising edge.
REQ-008 SHALL have ports s_real and s_imag, input, WIDTH bits each: upstream sample.
REQ-009 SHALL have port core_input_en, output, 1 bit: drives the FFT core input_en.
REQ-010 SHALL have ports core_input_real and core_input_imag, output, WIDTH bits each: drive the core inputs.
REQ-011 SHALL have port core_output_en, input, 1 bit: FFT core output_en.
REQ-012 SHALL have ports core_output_real and core_output_imag, input, WIDTH bits each: FFT core outputs.
REQ-013 SHALL have port m_valid, output, 1 bit: result valid; there is no backpressure.
REQ-014 SHALL have ports m_real and m_imag, output, WIDTH bits each: result sample.
REQ-015 SHALL have port m_index, output, log2(N) bits: bin position within the frame.
REQ-016 SHALL have ports m_first and m_last, output, 1 bit each: frame boundary markers.
REQ-017 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-018 SHALL have port frame_count, output, 16 bits: completed frames, wrapping at 2^16.
REQ-019 SHALL have ports err_timeout and err_spurious, output, 1 bit each: sticky error flags.

Function
REQ-020 SHALL implement states IDLE, FILL, ISSUE and DRAIN.
REQ-021 SHALL drive s_ready high in IDLE and FILL and low in ISSUE and DRAIN.
REQ-022 SHALL, in IDLE, on an accepted sample, write it to buffer[0], set wr_cnt=1 and go to FILL.
REQ-023 SHALL, in FILL, write each accepted sample to buffer[wr_cnt] and increment wr_cnt; gaps in s_valid only stall the fill.
REQ-024 SHALL go to ISSUE, with rd_cnt=0, on the edge that accepts sample N-1.
REQ-025 SHALL, in ISSUE, assert core_input_en for exactly N consecutive cycles with no gaps, starting the cycle after the last sample is accepted.
REQ-026 SHALL present buffer[0..N-1] on core_input_real/imag in acceptance order during ISSUE, one sample per cycle.
REQ-027 SHALL go to DRAIN after the N-th ISSUE cycle, clearing out_cnt and the timeout counter.
REQ-028 SHALL drive core_input_en low, and core_input_real/imag to 0, outside ISSUE.
REQ-029 SHALL, in DRAIN, register each cycle with core_output_en high into m_real/m_imag and assert m_valid one cycle later.
REQ-030 SHALL set m_index=out_cnt, m_first=(out_cnt==0) and m_last=(out_cnt==N-1) for each result, then increment out_cnt.
REQ-031 SHALL, on the N-th core output, go to IDLE and increment frame_count; s_ready is high in the following cycle.
REQ-032 SHALL count DRAIN cycles without core_output_en and clear that count on every core_output_en.
REQ-033 SHALL, when the DRAIN idle count reaches TIMEOUT, set err_timeout, go to IDLE and leave frame_count unchanged.
REQ-034 SHALL ignore core_output_en outside DRAIN: no m_valid, and err_spurious is set.
REQ-035 SHALL keep m_valid, m_first and m_last low when there is no result; m_real, m_imag and m_index hold their last values.
REQ-036 SHALL not modify upstream or core data; it has no arithmetic other than counters.
REQ-037 SHALL leave the error flags set until reset; errors do not block later frames.

Reset
REQ-038 SHALL, while reset is high at a rising edge, set state=IDLE, clear all counters, and drive all outputs low/0 except s_ready, which is high.
REQ-039 SHALL, on reset in any state, abort the current frame with no further core_input_en or m_valid for that frame; buffer contents are don't-care.

Verification
REQ-040 SHALL cover: 16 back-to-back samples, real=32768,30274,23170,...,30274 (cosine table), imag=0 -> core_input_en high for 16 consecutive cycles starting 1 cycle after the 16th accept, with identical values in order.
REQ-041 SHALL cover: s_valid high on alternate cycles only -> fill takes 31 cycles; the ISSUE burst is still 16 contiguous cycles; s_ready is low throughout ISSUE and DRAIN.
REQ-042 SHALL cover: a core model echoing 16 outputs after latency 20 with one 3-cycle gap -> m_valid on 16 cycles, m_index 0..15, m_first at 0, m_last at 15, frame_count=1.
REQ-043 SHALL cover: TIMEOUT=8 and a core model that produces only 5 outputs -> err_timeout=1 exactly 8 idle cycles after the 5th output, return to IDLE, frame_count unchanged, and a following frame completes.
REQ-044 SHALL cover: reset asserted on the 7th ISSUE cycle -> the next cycle has core_input_en=0, s_ready=1, busy=0 and frame_count=0.
REQ-045 SHALL cover: core_output_en pulsed in IDLE -> err_spurious=1 and m_valid stays 0.
